// File: rtl/nes_clk_pkg.sv
// Shared types and divider constants for the NES clock-enable generator.
// NES_CLKGEN_PAL_EN selects PAL divisors; NTSC divisors when undefined.
package nes_clk_pkg;

  typedef enum logic [1:0] {
    StWaitLock,
    StSettle,
    StRun
  } clk_state_e;

`ifdef NES_CLKGEN_PAL_EN
  localparam int unsigned PPU_DIV = 5;
  localparam int unsigned CPU_DIV = 16;
`else
  localparam int unsigned PPU_DIV = 4;
  localparam int unsigned CPU_DIV = 12;
`endif

  localparam int unsigned MCNT_W = $clog2(CPU_DIV);
  localparam int unsigned PCNT_W = $clog2(PPU_DIV);

endpackage

// File: rtl/nes_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Asynchronous active-high reset clears both stages to 0.
module nes_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/nes_clock_gen.sv
// Master-clock enable generator: lock qualification, PPU/CPU/APU enables and system reset.
// NES_CLKGEN_PAL_EN (via nes_clk_pkg) switches to PAL divisors.
module nes_clock_gen
  import nes_clk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CPU_PHASE     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic pause,
  output logic ppu_ce,
  output logic cpu_ce,
  output logic apu_ce,
  output logic sys_rst,
  output logic running
);

  if (CPU_PHASE >= CPU_DIV) begin : g_phase_chk
    $error("CPU_PHASE must be below CPU_DIV");
  end

  localparam logic [15:0]       SettleLast = 16'(SETTLE_CYCLES - 1);
  localparam logic [MCNT_W-1:0] McntLast   = MCNT_W'(CPU_DIV - 1);
  localparam logic [MCNT_W-1:0] CpuHit     = MCNT_W'(CPU_PHASE);
  localparam logic [PCNT_W-1:0] PcntLast   = PCNT_W'(PPU_DIV - 1);

  logic locked_s;

  nes_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );

  clk_state_e        state_d, state_q;
  logic [15:0]       settle_d, settle_q;
  logic [MCNT_W-1:0] mcnt_d, mcnt_q;
  logic [PCNT_W-1:0] pcnt_d, pcnt_q, pcnt_step;
  logic              tog_d, tog_q;
  logic              frozen_d, frozen_q;
  logic              run_d, active_d;
  logic              ppu_ce_d, ppu_ce_q;
  logic              cpu_ce_d, cpu_ce_q;
  logic              apu_ce_d, apu_ce_q;
  logic              sys_rst_d, sys_rst_q;
  logic              running_d, running_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      StWaitLock: begin
        settle_d = '0;
        if (locked_s) state_d = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleLast) state_d = StRun;
        else                        settle_d = settle_q + 16'd1;
      end
      StRun:   state_d = StRun;
      default: state_d = StWaitLock;
    endcase
    // Lock loss overrides everything and restarts the full settle period.
    if (!locked_s) begin
      state_d  = StWaitLock;
      settle_d = '0;
    end
  end

  always_comb begin
    pcnt_step = (pcnt_q == PcntLast) ? '0 : pcnt_q + 1'b1;
    run_d     = (state_d == StRun);
    mcnt_d    = '0;
    pcnt_d    = '0;
    frozen_d  = 1'b0;
    tog_d     = 1'b0;
    if (run_d) begin
      tog_d = tog_q;
      if (state_q == StRun) begin
        if (frozen_q) begin
          frozen_d = pause;
        end else if (mcnt_q == McntLast) begin
          // Pause only takes effect on a period boundary so no pattern is truncated.
          frozen_d = pause;
          if (!pause) pcnt_d = pcnt_step;
        end else begin
          mcnt_d = mcnt_q + 1'b1;
          pcnt_d = pcnt_step;
        end
      end
    end
    active_d  = run_d && !frozen_d;
    ppu_ce_d  = active_d && (pcnt_d == '0);
    cpu_ce_d  = active_d && (mcnt_d == CpuHit);
    apu_ce_d  = cpu_ce_d && !tog_q;
    if (cpu_ce_d) tog_d = ~tog_q;
    sys_rst_d = !run_d;
    running_d = run_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StWaitLock;
      settle_q  <= '0;
      mcnt_q    <= '0;
      pcnt_q    <= '0;
      tog_q     <= 1'b0;
      frozen_q  <= 1'b0;
      ppu_ce_q  <= 1'b0;
      cpu_ce_q  <= 1'b0;
      apu_ce_q  <= 1'b0;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      mcnt_q    <= mcnt_d;
      pcnt_q    <= pcnt_d;
      tog_q     <= tog_d;
      frozen_q  <= frozen_d;
      ppu_ce_q  <= ppu_ce_d;
      cpu_ce_q  <= cpu_ce_d;
      apu_ce_q  <= apu_ce_d;
      sys_rst_q <= sys_rst_d;
      running_q <= running_d;
    end
  end

  assign ppu_ce  = ppu_ce_q;
  assign cpu_ce  = cpu_ce_q;
  assign apu_ce  = apu_ce_q;
  assign sys_rst = sys_rst_q;
  assign running = running_q;

endmodule

// File: tb/tb_nes_clock_gen.sv
// Scoreboard bench for nes_clock_gen: two instances (CPU_PHASE 0 and 5) against a cycle-count model.
module tb_nes_clock_gen;

  localparam int Settle = 16;
  localparam int Phase1 = 5;
`ifdef NES_CLKGEN_PAL_EN
  localparam int PpuDiv = 5;
  localparam int CpuDiv = 16;
`else
  localparam int PpuDiv = 4;
  localparam int CpuDiv = 12;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic pause = 1'b0;
  logic ppu0, cpu0, apu0, srst0, run0;
  logic ppu1, cpu1, apu1, srst1, run1;

  always #5 clk = ~clk;

  nes_clock_gen #(.SETTLE_CYCLES(Settle), .CPU_PHASE(0)) u_dut0 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pause(pause),
    .ppu_ce(ppu0), .cpu_ce(cpu0), .apu_ce(apu0), .sys_rst(srst0), .running(run0)
  );

  nes_clock_gen #(.SETTLE_CYCLES(Settle), .CPU_PHASE(Phase1)) u_dut1 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pause(pause),
    .ppu_ce(ppu1), .cpu_ce(cpu1), .apu_ce(apu1), .sys_rst(srst1), .running(run1)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] sb[$];

  // Model: run once locked_s has been seen high for Settle+1 consecutive edges;
  // m_act counts unfrozen RUN cycles, m_pact counts since the last PPU-phase clear.
  bit m_s1, m_s2, m_run, m_frz;
  int m_hi, m_act, m_pact;

  task automatic model_edge(input bit lk, input bit ps);
    bit ls, nr;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_frz = 0; m_hi = 0; m_act = 0; m_pact = 0;
      return;
    end
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    m_hi = ls ? ((m_hi < 1000000) ? m_hi + 1 : m_hi) : 0;
    nr = (m_hi >= Settle + 1);
    if (!nr || !m_run) begin
      m_frz = 0; m_act = 0; m_pact = 0;
    end else if (m_frz) begin
      if (!ps) m_frz = 0;
    end else if ((m_act % CpuDiv == CpuDiv - 1) && ps) begin
      m_frz = 1; m_act++; m_pact = 0;
    end else begin
      m_act++; m_pact++;
    end
    m_run = nr;
  endtask

  function automatic logic [9:0] model_out();
    bit a, p, c0, a0, c1, a1, even;
    a = m_run && !m_frz;
    even = ((m_act / CpuDiv) % 2) == 0;
    p = a && (m_pact % PpuDiv == 0);
    c0 = a && (m_act % CpuDiv == 0);
    a0 = c0 && even;
    c1 = a && (m_act % CpuDiv == Phase1);
    a1 = c1 && even;
    return {p, c0, a0, !m_run, m_run, p, c1, a1, !m_run, m_run};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input bit lk, input bit ps);
    pll_locked = lk;
    pause = ps;
    @(posedge clk);
    model_edge(lk, ps);
    sb.push_back(model_out());
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [9:0] e, g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!rst) begin
        g = {ppu0, cpu0, apu0, srst0, run0, ppu1, cpu1, apu1, srst1, run1};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got %b expected %b (ppu,cpu,apu,sys_rst,running x2)",
                   $time, g, e);
        end
      end
    end
  end

  initial begin
    int n, cp, cc, ca, c5, zen, drop_left;
    bit ps_r;

    repeat (5) @(posedge clk);
    #1;
    check("reset sys_rst", srst0, 1);
    check("reset running", run0, 0);
    check("reset enables", int'({ppu0, cpu0, apu0, ppu1, cpu1, apu1}), 0);
    rst = 1'b0;
    repeat (4) step(0, 0);

    n = 0;
    do begin step(1, 0); n++; end while (srst0 && n < 200);
    check("lock-to-run latency", n, Settle + 3);
    check("first run ppu_ce", ppu0, 1);
    check("first run cpu_ce", cpu0, 1);

    cp = ppu0; cc = cpu0; ca = apu0; c5 = cpu1;
    repeat (239) begin
      step(1, 0);
      cp += ppu0; cc += cpu0; ca += apu0; c5 += cpu1;
    end
    check("ppu_ce count/240", cp, 240 / PpuDiv);
    check("cpu_ce count/240", cc, 240 / CpuDiv);
    check("apu_ce count/240", ca, (240 / CpuDiv + 1) / 2);
    check("phase5 cpu_ce count/240", c5, 240 / CpuDiv);

    n = 0;
    while ((m_act % CpuDiv) != 3 && n < 40) begin step(1, 0); n++; end
    zen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 1);
      if (i >= 14) zen += ppu0 + cpu0 + apu0 + ppu1 + cpu1 + apu1;
    end
    check("frozen enables", zen, 0);
    step(1, 0);
    check("release ppu_ce", ppu0, 1);
    check("release cpu_ce", cpu0, 1);
    repeat (20) step(1, 0);

    repeat (3) step(0, 0);
    check("lock drop sys_rst", srst0, 1);
    check("lock drop enables", int'({ppu0, cpu0, apu0, ppu1, cpu1, apu1}), 0);

    repeat (10) step(1, 0);
    step(0, 0);
    n = 0;
    do begin step(1, 0); n++; end while (srst0 && n < 200);
    check("settle glitch restart", n, Settle + 3);

    drop_left = 0;
    ps_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left > 0) drop_left--;
      else if ($urandom_range(0, 299) == 0) drop_left = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) ps_r = !ps_r;
      step(drop_left == 0, ps_r);
    end

    n = 0;
    do begin step(1, 0); n++; end while (!run0 && n < 100);
    check("pre-reset running", run0, 1);
    #2 rst = 1'b1;
    #1;
    check("async rst dut0", int'({ppu0, cpu0, apu0, srst0, run0}), 2);
    check("async rst dut1", int'({ppu1, cpu1, apu1, srst1, run1}), 2);
    #3;
    repeat (3) step(1, 0);
    rst = 1'b0;
    n = 0;
    do begin step(1, 0); n++; end while (srst0 && n < 200);
    check("post-reset latency", n, Settle + 3);
    repeat (100) step(1, $urandom_range(0, 3) == 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_clock_gen.md
# nes_clock_gen

Converts the PLL master clock (21.477272 MHz NTSC, ÷1) and its lock flag into the system's clock-enable set. Produces PPU (÷4), CPU (÷12) and APU (÷24) single-cycle enables plus a qualified system reset. It sits directly downstream of the master PLL; every other block in the design runs on `clk` and is gated by these enables.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1024: cycles `locked` must stay high before running; legal range 2..65535.
- `CPU_PHASE`, default 0: master-cycle index (0..CPU_DIV-1) at which `cpu_ce` fires; sets CPU/PPU alignment.

Ports (one clock domain; reset is asynchronous, active-high):
- `clk` in 1: master clock, the PLL's `outclk_0`.
- `rst` in 1: asynchronous, active-high reset, same net that drives the PLL `rst`.
- `pll_locked` in 1: PLL `locked`; treated as asynchronous.
- `pause` in 1: synchronous freeze request.
- `ppu_ce` out 1: PPU clock enable.
- `cpu_ce` out 1: CPU clock enable.
- `apu_ce` out 1: APU enable, every second `cpu_ce`.
- `sys_rst` out 1: active-high reset for the rest of the design.
- `running` out 1: high in RUN state.

## Operation

- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`, adding 2 cycles of latency.
- FSM states: WAIT_LOCK, SETTLE, RUN.
  - WAIT_LOCK: go to SETTLE when `locked_s`=1. The settle counter clears.
  - SETTLE: the settle counter increments each cycle. If `locked_s`=0, return to WAIT_LOCK and clear the counter. When the counter reaches SETTLE_CYCLES-1, go to RUN.
  - RUN: if `locked_s`=0, go to WAIT_LOCK immediately. Loss of lock in any state forces WAIT_LOCK.
- Master phase counter `mcnt`:
  - Counts 0..CPU_DIV-1 and wraps.
  - Forced to 0 outside RUN; starts at 0 in the first RUN cycle.
- APU toggle bit:
  - Flips on each `cpu_ce`.
  - Cleared outside RUN.
- Enable decode in RUN, when not frozen:
  - `ppu_ce`=1 when `mcnt` mod PPU_DIV = 0.
  - `cpu_ce`=1 when `mcnt` = CPU_PHASE.
  - `apu_ce`=1 when `cpu_ce`=1 and the toggle bit = 0.
- Pause:
  - `pause` is sampled only at `mcnt`=CPU_DIV-1. If it is 1, the block enters the frozen condition: `mcnt` holds at 0 and all enables are 0.
  - While frozen, `pause` is sampled every cycle. The first cycle after `pause`=0 is sampled, `mcnt`=0 with enables active.
  - Enable patterns therefore never truncate mid-period.
- `sys_rst`:
  - 1 in WAIT_LOCK and SETTLE.
  - 0 in RUN.
  - Reasserts in the cycle after lock loss is seen on `locked_s`.

## Timing

- Reset values, asynchronous on `rst`=1: `sys_rst`=1, all enables 0, `running`=0, FSM=WAIT_LOCK, counters 0, synchronizer flops 0.
- All outputs are registered. Each enable is high for exactly one `clk` cycle, in the cycle where `mcnt` equals its target. They are decoded from next-state values so there is no extra latency.
- Lock to run: RUN is entered 2 + 1 + SETTLE_CYCLES cycles after `pll_locked` rises, provided it is stable. `sys_rst` falls and `running` rises on that same edge.
- Lock glitch during SETTLE: the full SETTLE_CYCLES count restarts.
- Lock loss in RUN: enables go to 0 and `sys_rst` goes to 1 on the edge after `locked_s` falls. There is no partial period afterwards.
- `pause` and lock loss together: lock loss wins. The frozen condition clears.
- `rst` asserted mid-RUN: all outputs take their reset values asynchronously. The block restarts from WAIT_LOCK.

## Configuration

- `NES_CLKGEN_PAL_EN`:
  - Defined: PAL divisors, PPU_DIV=5 and CPU_DIV=16. APU stays at every second `cpu_ce`. The `mcnt` width is sized for 16.
  - Undefined: NTSC divisors, PPU_DIV=4 and CPU_DIV=12.
- With PAL divisors, `ppu_ce` is the `mcnt` mod 5 = 0 decode within the 16-cycle period. The PPU/CPU alignment therefore repeats every 80 cycles, not every 16; the decode is kept in a separate mod-5 counter that clears with `mcnt`.
- CPU_PHASE must satisfy CPU_PHASE < CPU_DIV under the active macro. This is checked by an elaboration-time assertion.

## Structure

- Package `nes_clk_pkg` holds:
  - the FSM state enum (WAIT_LOCK, SETTLE, RUN);
  - constants PPU_DIV, CPU_DIV and MCNT_W, selected by `NES_CLKGEN_PAL_EN`.
- Sub-module `nes_sync2`: generic 2-flop synchronizer for `pll_locked`, with asynchronous active-high reset to 0. It is reused elsewhere for asynchronous inputs.
- All counters and the FSM live in `nes_clock_gen`.

## Test plan

- Power-up: `rst`=1 for 5 cycles, then `pll_locked`=1 at cycle 10 with SETTLE_CYCLES=16 -> `sys_rst` falls exactly 19 cycles after `pll_locked` rises; the first RUN cycle has `ppu_ce`=1 and `cpu_ce`=1.
- Steady NTSC run over 240 cycles with CPU_PHASE=0 -> 60 `ppu_ce`, 20 `cpu_ce` and 10 `apu_ce` pulses; `cpu_ce` is always coincident with `ppu_ce`.
- CPU_PHASE=5 -> `cpu_ce` at `mcnt`=5, never coincident with `ppu_ce`; `ppu_ce` stays at `mcnt` 0, 4, 8.
- Lock glitch: `pll_locked` low for 1 cycle midway through SETTLE -> the FSM returns to WAIT_LOCK and RUN arrives a full SETTLE period after relock. Lock drop in RUN -> `sys_rst`=1 and enables 0 within 3 cycles.
- Pause: `pause`=1 asserted at `mcnt`=3 and released 30 cycles later -> the current 12-cycle period completes with normal pulses, then zero enables. After release, the pattern restarts at `mcnt`=0 with `ppu_ce`=1. The `apu_ce` toggle bit is preserved across the freeze.
- PAL build (`NES_CLKGEN_PAL_EN` defined), run for 80 cycles -> 16 `ppu_ce` and 5 `cpu_ce` pulses; asynchronous `rst` mid-run forces all outputs to reset values in the same cycle.
